// File: rtl/os_ctrl_pkg.sv
// Shared definitions for the output-stationary sequencer: instruction bit map,
// idle instruction word and FSM state encoding.
package os_ctrl_pkg;

  localparam int unsigned InstW      = 41;
  localparam int unsigned IssueDepth = 3;
  localparam int unsigned FlushCyc   = 3;

  localparam int unsigned BitMaxPool  = 40;
  localparam int unsigned BitBypass   = 39;
  localparam int unsigned BitAcc      = 38;
  localparam int unsigned BitCenPmem  = 37;
  localparam int unsigned BitWenPmem  = 36;
  localparam int unsigned APmemLsb    = 27;
  localparam int unsigned BitCen1Xmem = 26;
  localparam int unsigned A1XmemLsb   = 18;
  localparam int unsigned BitCen0Xmem = 17;
  localparam int unsigned BitWen0Xmem = 16;
  localparam int unsigned A0XmemLsb   = 8;
  localparam int unsigned BitOfifoRd  = 7;
  localparam int unsigned BitIfifoWr  = 6;
  localparam int unsigned BitIfifoRd  = 5;
  localparam int unsigned BitL0Rd     = 4;
  localparam int unsigned BitL0Wr     = 3;
  localparam int unsigned BitMode     = 2;
  localparam int unsigned BitExecute  = 1;
  localparam int unsigned BitLoad     = 0;

  // All memories disabled, xmem port 0 in read mode, everything else low.
  localparam logic [InstW-1:0] InstIdle = (InstW'(1) << BitCenPmem)
                                        | (InstW'(1) << BitWenPmem)
                                        | (InstW'(1) << BitCen1Xmem)
                                        | (InstW'(1) << BitCen0Xmem)
                                        | (InstW'(1) << BitWen0Xmem);

  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StExec  = 3'd1;
  localparam state_t StFlush = 3'd2;
  localparam state_t StDrain = 3'd3;
  localparam state_t StRead  = 3'd4;
  localparam state_t StDone  = 3'd5;

  // Byte address offset, wrapping modulo 256.
  function automatic logic [7:0] addr_add(logic [7:0] base, logic [7:0] offs);
    return base + offs;
  endfunction

endpackage

// File: rtl/os_issue_pipe.sv
// Valid shift register timing the L0/IFIFO write, read and PE execute strobes
// one, two and three cycles after an xmem issue.
module os_issue_pipe
  import os_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic issue,
  output logic wr_stage,
  output logic rd_stage,
  output logic exec_stage
);

  logic [IssueDepth-1:0] pipe_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[IssueDepth-2:0], issue};
    end
  end

  assign wr_stage   = pipe_q[0];
  assign rd_stage   = pipe_q[1];
  assign exec_stage = pipe_q[2];

endmodule

// File: rtl/os_seq_ctrl.sv
// Output-stationary core sequencer: issue, flush, drain, readout, done.
// Optional OS_MAXPOOL_EN mirrors ofifo_rd onto max_pool_en during readout.
module os_seq_ctrl
  import os_ctrl_pkg::*;
#(
  parameter int unsigned LEN_NIJ   = 27,
  parameter int unsigned DRAIN_CYC = 16,
  parameter int unsigned N_OUT     = 8,
  parameter logic [7:0]  X_BASE    = 8'h00,
  parameter logic [7:0]  W_BASE    = 8'h80
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             l0_ready,
  input  logic             ififo_ready,
  input  logic             ofifo_valid,
  output logic [InstW-1:0] inst,
  output logic             busy,
  output logic             done
);

  localparam int unsigned KW = (LEN_NIJ > 1) ? $clog2(LEN_NIJ) : 1;
  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int unsigned RW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [KW-1:0] KLast     = KW'(LEN_NIJ - 1);
  localparam logic [DW-1:0] DrainLast = DW'(DRAIN_CYC - 1);
  localparam logic [RW-1:0] ReadLast  = RW'(N_OUT - 1);
  localparam logic [1:0]    FlushLast = 2'(FlushCyc - 1);

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [1:0]       flush_q, flush_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [RW-1:0]    rd_q, rd_d;
  logic [InstW-1:0] inst_q, inst_d;

  logic issue;
  logic wr_stage, rd_stage, exec_stage;

  os_issue_pipe u_issue_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .issue      (issue),
    .wr_stage   (wr_stage),
    .rd_stage   (rd_stage),
    .exec_stage (exec_stage)
  );

  assign issue = (state_q == StExec) && l0_ready && ififo_ready;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    flush_d = flush_q;
    drain_d = drain_q;
    rd_d    = rd_q;
    inst_d  = InstIdle;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StExec;
          k_d     = '0;
        end
      end
      StExec: begin
        // Addresses always point at the pending vector; a stall only gates CEN.
        inst_d[A0XmemLsb +: 8] = addr_add(X_BASE, 8'(k_q));
        inst_d[A1XmemLsb +: 8] = addr_add(W_BASE, 8'(k_q));
        if (issue) begin
          inst_d[BitCen0Xmem] = 1'b0;
          inst_d[BitCen1Xmem] = 1'b0;
          if (k_q == KLast) begin
            k_d     = '0;
            flush_d = '0;
            state_d = StFlush;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      StFlush: begin
        if (flush_q == FlushLast) begin
          flush_d = '0;
          drain_d = '0;
          state_d = StDrain;
        end else begin
          flush_d = flush_q + 2'd1;
        end
      end
      StDrain: begin
        inst_d[BitMode] = 1'b1;
        inst_d[BitLoad] = 1'b1;
        if (drain_q == DrainLast) begin
          drain_d = '0;
          rd_d    = '0;
          state_d = StRead;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      StRead: begin
        if (ofifo_valid) begin
          inst_d[BitOfifoRd] = 1'b1;
          if (rd_q == ReadLast) begin
            rd_d    = '0;
            state_d = StDone;
          end else begin
            rd_d = rd_q + RW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    inst_d[BitL0Wr]    = wr_stage;
    inst_d[BitIfifoWr] = wr_stage;
    inst_d[BitL0Rd]    = rd_stage;
    inst_d[BitIfifoRd] = rd_stage;
    inst_d[BitExecute] = exec_stage;
    inst_d[BitMode]    = inst_d[BitMode] | exec_stage;

`ifdef OS_MAXPOOL_EN
    inst_d[BitMaxPool] = inst_d[BitOfifoRd];
`else
    inst_d[BitMaxPool] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      flush_q <= '0;
      drain_q <= '0;
      rd_q    <= '0;
      inst_q  <= InstIdle;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      flush_q <= flush_d;
      drain_q <= drain_d;
      rd_q    <= rd_d;
      inst_q  <= inst_d;
    end
  end

  assign inst = inst_q;
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_os_seq_ctrl.sv
// Self-checking bench for os_seq_ctrl: directed and randomised runs against an
// event-scheduling reference model of the sequencer behaviour.
module tb_os_seq_ctrl;

  localparam int unsigned LEN  = 27;
  localparam int unsigned DR   = 16;
  localparam int unsigned NO   = 8;
  localparam logic [7:0]  XB   = 8'h00;
  localparam logic [7:0]  WB   = 8'h80;
  localparam int          SCHN = 16384;

  logic        clk = 1'b0;
  logic        reset_n, start, l0_ready, ififo_ready, ofifo_valid;
  logic [40:0] inst;
  logic        busy, done;

  os_seq_ctrl #(
    .LEN_NIJ   (LEN),
    .DRAIN_CYC (DR),
    .N_OUT     (NO),
    .X_BASE    (XB),
    .W_BASE    (WB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .l0_ready    (l0_ready),
    .ififo_ready (ififo_ready),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 exec, 2 flush, 3 drain, 4 read, 5 done.
  int   phase, k, cnt, cyc;
  bit   sch_wr[SCHN];
  bit   sch_rd[SCHN];
  bit   sch_ex[SCHN];
  logic [40:0] exp_inst;
  logic exp_busy, exp_done;

  int checks = 0;
  int errors = 0;

  int n_iss, n_ex, n_ld, n_rd, n_done, first_iss, first_ex, last_ex;
  logic [7:0] first_a0, last_a0, last_a1;

  function automatic logic [40:0] mk_word(logic cen, logic [7:0] a0, logic [7:0] a1,
                                           logic wr, logic rd, logic ex, logic mode,
                                           logic load, logic ordd);
    logic [40:0] w;
    w = '0;
    w[37] = 1'b1;
    w[36] = 1'b1;
    w[26] = cen;
    w[25:18] = a1;
    w[17] = cen;
    w[16] = 1'b1;
    w[15:8] = a0;
    w[7] = ordd;
    w[6] = wr;
    w[5] = rd;
    w[4] = rd;
    w[3] = wr;
    w[2] = mode;
    w[1] = ex;
    w[0] = load;
`ifdef OS_MAXPOOL_EN
    w[40] = ordd;
`endif
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    phase = 0;
    k = 0;
    cnt = 0;
    for (int i = 0; i < SCHN; i++) begin
      sch_wr[i] = 1'b0;
      sch_rd[i] = 1'b0;
      sch_ex[i] = 1'b0;
    end
    exp_inst = mk_word(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endtask

  // Predict the registered outputs seen after the next rising edge.
  task automatic model_step(input logic st, input logic l0r, input logic ifr, input logic ov);
    int t;
    logic cen, ld, md, ordd;
    logic [7:0] a0, a1;
    t = cyc + 1;
    cen = 1'b1; ld = 1'b0; md = 1'b0; ordd = 1'b0; a0 = 8'h00; a1 = 8'h00;
    case (phase)
      0: if (st) begin phase = 1; k = 0; end
      1: begin
        a0 = XB + 8'(k);
        a1 = WB + 8'(k);
        if (l0r && ifr) begin
          cen = 1'b0;
          sch_wr[t + 1] = 1'b1;
          sch_rd[t + 2] = 1'b1;
          sch_ex[t + 3] = 1'b1;
          k++;
          if (k == LEN) begin phase = 2; cnt = 0; end
        end
      end
      2: begin cnt++; if (cnt == 3) begin phase = 3; cnt = 0; end end
      3: begin
        ld = 1'b1; md = 1'b1; cnt++;
        if (cnt == DR) begin phase = 4; cnt = 0; end
      end
      4: if (ov) begin ordd = 1'b1; cnt++; if (cnt == NO) phase = 5; end
      default: phase = 0;
    endcase
    exp_inst = mk_word(cen, a0, a1, sch_wr[t], sch_rd[t], sch_ex[t], md | sch_ex[t], ld, ordd);
    exp_busy = (phase != 0);
    exp_done = (phase == 5);
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_inst"}, 64'(inst), 64'(exp_inst));
    chk({tag, "_busy"}, 64'(busy), 64'(exp_busy));
    chk({tag, "_done"}, 64'(done), 64'(exp_done));
  endtask

  // Called at a falling edge: drive inputs, clock once, check at the next falling edge.
  task automatic step(input logic st, input logic l0r, input logic ifr, input logic ov);
    start = st; l0_ready = l0r; ififo_ready = ifr; ofifo_valid = ov;
    model_step(st, l0r, ifr, ov);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_out("cyc");
    if (!inst[17]) begin
      if (n_iss == 0) begin first_iss = cyc; first_a0 = inst[15:8]; end
      n_iss++;
      last_a0 = inst[15:8];
      last_a1 = inst[25:18];
    end
    if (inst[1]) begin
      if (n_ex == 0) first_ex = cyc;
      n_ex++;
      last_ex = cyc;
    end
    if (inst[0] && inst[2]) n_ld++;
    if (inst[7]) n_rd++;
    if (done) n_done++;
  endtask

  // mode 0: readies high, ofifo_valid toggles every 2 cycles
  // mode 1: l0_ready low on exec cycles 5-7, stray start in exec
  // mode 2: random readies, valid and start
  task automatic run(input int mode, input bit abort_in_drain);
    int steps, eidx, this_eidx;
    logic st, l0r, ifr, ov;
    n_iss = 0; n_ex = 0; n_ld = 0; n_rd = 0; n_done = 0;
    first_iss = 0; first_ex = 0; last_ex = 0;
    first_a0 = 8'hxx; last_a0 = 8'hxx; last_a1 = 8'hxx;
    eidx = 0;
    steps = 0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    while (phase != 0 && steps < 1000) begin
      if (abort_in_drain && phase == 3 && cnt == 5) break;
      this_eidx = (phase == 1) ? eidx : -1;
      if (phase == 1) eidx++;
      case (mode)
        0: begin
          st = 1'b0; l0r = 1'b1; ifr = 1'b1; ov = logic'((cyc >> 1) & 1);
        end
        1: begin
          st = (this_eidx == 10);
          l0r = !(this_eidx >= 5 && this_eidx <= 7);
          ifr = 1'b1;
          ov = 1'b1;
        end
        default: begin
          st = ($urandom_range(0, 7) == 0);
          l0r = ($urandom_range(0, 3) != 0);
          ifr = ($urandom_range(0, 3) != 0);
          ov = logic'($urandom_range(0, 1));
        end
      endcase
      step(st, l0r, ifr, ov);
      if (mode == 1 && this_eidx >= 5 && this_eidx <= 7) begin
        chk("stall_cen0", 64'(inst[17]), 64'd1);
        chk("stall_cen1", 64'(inst[26]), 64'd1);
        chk("stall_a0", 64'(inst[15:8]), 64'h05);
      end
      steps++;
    end

    if (abort_in_drain) begin
      #2 reset_n = 1'b0;
      #1 model_reset();
      check_out("rst_drain");
      @(negedge clk);
      reset_n = 1'b1;
      return;
    end

    chk("run_end_busy", 64'(busy), 64'd0);
    chk("n_issue", 64'(n_iss), 64'(LEN));
    chk("n_execute", 64'(n_ex), 64'(LEN));
    chk("n_drain_load", 64'(n_ld), 64'(DR));
    chk("n_ofifo_rd", 64'(n_rd), 64'(NO));
    chk("n_done", 64'(n_done), 64'd1);
    chk("first_a0", 64'(first_a0), 64'(XB));
    if (mode == 0) begin
      chk("exec_lag", 64'(first_ex - first_iss), 64'd3);
      chk("exec_span", 64'(last_ex - first_ex + 1), 64'(LEN));
      chk("last_a0", 64'(last_a0), 64'h1A);
      chk("last_a1", 64'(last_a1), 64'h9A);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    l0_ready = 1'b0;
    ififo_ready = 1'b0;
    ofifo_valid = 1'b0;
    cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_out("reset");
    reset_n = 1'b1;

    run(0, 1'b0);
    run(1, 1'b0);
    run(0, 1'b1);
    run(0, 1'b0);
    run(2, 1'b0);
    run(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
